// File: rtl/arm_alu_mc_pkg.sv
// Shared definitions for the multicycle ALU: operation codes and FSM states.
// Any 4-bit code that is not listed in op_e is reserved.
package arm_alu_mc_pkg;

  typedef enum logic [3:0] {
    OP_SUB = 4'b0000,
    OP_ADD = 4'b0001,
    OP_ORR = 4'b0010,
    OP_AND = 4'b0011,
    OP_SBC = 4'b0100,
    OP_ADC = 4'b0101,
    OP_EOR = 4'b0111,
    OP_MUL = 4'b1000
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  function automatic logic is_mul(input logic [3:0] op);
    return op == OP_MUL;
  endfunction

endpackage

// File: rtl/arm_alu_mc_if.sv
// Command/result bundle between the controller and the multicycle ALU.
//   master: the controller. It drives start, op, inpa, inpb, cin and vin.
//   slave:  the ALU. It drives busy, done, result and the N/Z/C/V flags.
interface arm_alu_mc_if #(parameter int WIDTH = 32);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] inpa;
  logic [WIDTH-1:0] inpb;
  logic             cin;
  logic             vin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             negative;
  logic             zero;
  logic             cout;
  logic             overflow;

  modport master (
    output start, op, inpa, inpb, cin, vin,
    input  busy, done, result, negative, zero, cout, overflow
  );

  modport slave (
    input  start, op, inpa, inpb, cin, vin,
    output busy, done, result, negative, zero, cout, overflow
  );
endinterface

// File: rtl/arm_alu_mc_alu_core.sv
// Combinational add/sub/logic datapath with NZCV generation.
//   op      operation code
//   a, b    operands
//   cin     incoming C flag; used as the carry for ADC and SBC and passed through otherwise
//   vin     incoming V flag; passed through for non-arithmetic ops
//   result  WIDTH-bit result
//   n, z, c, v  flags for that result
// Subtraction is computed as a + ~b + carry, so c=1 means no borrow.
module alu_core
  import arm_alu_mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             vin,
  output logic [WIDTH-1:0] result,
  output logic             n,
  output logic             z,
  output logic             c,
  output logic             v
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] b_eff;
  logic             carry_in;
  logic             is_sub;

  always_comb begin
    b_eff    = b;
    carry_in = 1'b0;
    is_sub   = 1'b0;
    case (op)
      OP_SUB: begin b_eff = ~b; carry_in = 1'b1; is_sub = 1'b1; end
      OP_SBC: begin b_eff = ~b; carry_in = cin;  is_sub = 1'b1; end
      OP_ADC: carry_in = cin;
      default: ;
    endcase

    sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in};

    result = '0;
    c      = cin;
    v      = vin;
    case (op)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
        result = sum[MSB:0];
        c      = sum[WIDTH];
        // Overflow is computed from the original b, not from the inverted b_eff.
        if (is_sub) v = (a[MSB] != b[MSB]) && (sum[MSB] != a[MSB]);
        else        v = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_ORR:  result = a | b;
      OP_AND:  result = a & b;
      OP_EOR:  result = a ^ b;
      default: result = '0;
    endcase

    n = result[MSB];
    z = (result == '0);
  end

endmodule

// File: rtl/arm_alu_mc.sv
// Multicycle ALU. Single-cycle arithmetic and logic ops complete with latency 1.
// MUL is a fixed WIDTH-iteration shift-add multiply with latency WIDTH+1.
//   clk, reset  rising-edge clock and synchronous active-high reset
//   bus         slave side of arm_alu_mc_if (command in; busy, done, result and flags out)
// Outputs are registered and hold their values until the next op completes.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | accepts commands; non-MUL ops complete in the accepting cycle
// ST_MUL  | one shift-add iteration per cycle; busy=1 and start is ignored
module arm_alu_mc
  import arm_alu_mc_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input logic         clk,
  input logic         reset,
  arm_alu_mc_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e state, state_nxt;

  logic [WIDTH-1:0] mcand, mplier, acc;
  logic [CNT_W-1:0] cnt;
  logic             c_lat, v_lat;

  logic ld_mul, step, fin_single, fin_mul;

  op_e              core_op;
  logic [WIDTH-1:0] core_a, core_b, core_res;
  logic             core_cin, core_vin;
  logic             core_n, core_z, core_c, core_v;

  // During a multiply, the shared adder accumulates the current partial product.
  always_comb begin
    core_op  = op_e'(bus.op);
    core_a   = bus.inpa;
    core_b   = bus.inpb;
    core_cin = bus.cin;
    core_vin = bus.vin;
    if (state == ST_MUL) begin
      core_op  = OP_ADD;
      core_a   = acc;
      core_b   = mplier[0] ? mcand : '0;
      core_cin = 1'b0;
      core_vin = v_lat;
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op     (core_op),
    .a      (core_a),
    .b      (core_b),
    .cin    (core_cin),
    .vin    (core_vin),
    .result (core_res),
    .n      (core_n),
    .z      (core_z),
    .c      (core_c),
    .v      (core_v)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    ld_mul     = 1'b0;
    step       = 1'b0;
    fin_single = 1'b0;
    fin_mul    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          if (is_mul(bus.op)) begin
            ld_mul    = 1'b1;
            state_nxt = ST_MUL;
          end else begin
            fin_single = 1'b1;
          end
        end
      end
      ST_MUL: begin
        step = 1'b1;
        if (cnt == LAST_CNT) begin
          fin_mul   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.busy = (state == ST_MUL);

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand        <= '0;
      mplier       <= '0;
      acc          <= '0;
      cnt          <= '0;
      c_lat        <= 1'b0;
      v_lat        <= 1'b0;
      bus.done     <= 1'b0;
      bus.result   <= '0;
      bus.negative <= 1'b0;
      bus.zero     <= 1'b0;
      bus.cout     <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      bus.done <= fin_single | fin_mul;

      if (fin_single) begin
        bus.result   <= core_res;
        bus.negative <= core_n;
        bus.zero     <= core_z;
        bus.cout     <= core_c;
        bus.overflow <= core_v;
      end else if (fin_mul) begin
        bus.result   <= core_res;
        bus.negative <= core_n;
        bus.zero     <= core_z;
        bus.cout     <= c_lat;
        bus.overflow <= v_lat;
      end

      if (ld_mul) begin
        mcand  <= bus.inpa;
        mplier <= bus.inpb;
        acc    <= '0;
        cnt    <= '0;
        c_lat  <= bus.cin;
        v_lat  <= bus.vin;
      end else if (step) begin
        acc    <= core_res;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_arm_alu_mc.sv
module tb_arm_alu_mc;
  import arm_alu_mc_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   lat;
  int   busy_cnt;

  arm_alu_mc_if #(.WIDTH(32)) bus ();

  arm_alu_mc #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {28'd0, bus.negative, bus.zero, bus.cout, bus.overflow};
  endfunction

  // Presents a command for one clock edge, then returns #1 after that edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic v);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.inpa  = a;
    bus.inpb  = b;
    bus.cin   = c;
    bus.vin   = v;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Follows an accepted MUL until done. The bound prevents a hang if done never arrives.
  task automatic run_mul(input int abort_at);
    busy_cnt = 0;
    lat      = 1;
    while (!bus.done && lat < 40) begin
      if (bus.busy) busy_cnt++;
      if (lat == 5) begin
        bus.start = 1'b1;
        bus.op    = OP_ADD;
        bus.inpa  = 32'h1111_1111;
        bus.inpb  = 32'h2222_2222;
      end else begin
        bus.start = 1'b0;
      end
      if (lat == abort_at) reset = 1'b1;
      @(posedge clk);
      #1;
      lat++;
      if (reset) begin
        reset = 1'b0;
        break;
      end
    end
    bus.start = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 4'b0000;
    bus.inpa  = '0;
    bus.inpb  = '0;
    bus.cin   = 1'b0;
    bus.vin   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", bus.result, 32'h0);
    check("rst_flags", flags(), 32'h0);
    check("rst_busy_done", {30'd0, bus.busy, bus.done}, 32'h0);
    reset = 1'b0;

    issue(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    check("add_done", {31'd0, bus.done}, 32'h1);
    check("add_busy", {31'd0, bus.busy}, 32'h0);
    check("add_result", bus.result, 32'h8000_0000);
    check("add_flags", flags(), 32'h9);
    @(posedge clk); #1;
    check("add_done_drop", {31'd0, bus.done}, 32'h0);
    check("add_hold", bus.result, 32'h8000_0000);

    issue(OP_SUB, 32'h5, 32'h5, 1'b0, 1'b0);
    check("sub_eq_result", bus.result, 32'h0);
    check("sub_eq_flags", flags(), 32'h6);

    issue(OP_SUB, 32'h0, 32'h1, 1'b0, 1'b0);
    check("sub_borrow_result", bus.result, 32'hFFFF_FFFF);
    check("sub_borrow_flags", flags(), 32'h8);

    issue(OP_SBC, 32'h5, 32'h3, 1'b0, 1'b0);
    check("sbc_result", bus.result, 32'h1);
    check("sbc_flags", flags(), 32'h2);

    issue(OP_ADC, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    check("adc_result", bus.result, 32'h0);
    check("adc_flags", flags(), 32'h6);

    issue(OP_SUB, 32'h8000_0000, 32'h1, 1'b0, 1'b0);
    check("sub_ovf_result", bus.result, 32'h7FFF_FFFF);
    check("sub_ovf_flags", flags(), 32'h3);

    issue(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 1'b1);
    check("and_result", bus.result, 32'hF000_F000);
    check("and_flags", flags(), 32'hB);

    // ORR followed immediately by EOR on consecutive edges.
    issue(OP_ORR, 32'h0000_0F00, 32'h0000_00F0, 1'b0, 1'b1);
    bus.start = 1'b1;
    bus.op    = OP_EOR;
    bus.inpa  = 32'hFFFF_0000;
    bus.inpb  = 32'h0F0F_0F0F;
    bus.cin   = 1'b1;
    bus.vin   = 1'b0;
    check("orr_done", {31'd0, bus.done}, 32'h1);
    check("orr_result", bus.result, 32'h0000_0FF0);
    check("orr_flags", flags(), 32'h1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("eor_done", {31'd0, bus.done}, 32'h1);
    check("eor_result", bus.result, 32'hF0F0_0F0F);
    check("eor_flags", flags(), 32'hA);
    @(posedge clk); #1;
    check("eor_done_drop", {31'd0, bus.done}, 32'h0);

    issue(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0);
    check("rsv_done", {31'd0, bus.done}, 32'h1);
    check("rsv_result", bus.result, 32'h0);
    check("rsv_flags", flags(), 32'h6);

    issue(OP_MUL, 32'h0001_0001, 32'h0001_0001, 1'b1, 1'b0);
    check("mul1_busy_first", {30'd0, bus.busy, bus.done}, 32'h2);
    run_mul(0);
    check("mul1_done", {30'd0, bus.busy, bus.done}, 32'h1);
    check("mul1_latency", lat, 33);
    check("mul1_busy_cycles", busy_cnt, 32);
    check("mul1_result", bus.result, 32'h0002_0001);
    check("mul1_flags", flags(), 32'h2);
    @(posedge clk); #1;
    check("mul1_done_drop", {31'd0, bus.done}, 32'h0);
    check("mul1_hold", bus.result, 32'h0002_0001);

    issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    run_mul(0);
    check("mul2_latency", lat, 33);
    check("mul2_result", bus.result, 32'h0000_0001);
    check("mul2_flags", flags(), 32'h1);

    // Reset asserted in the 10th busy cycle aborts the multiply.
    issue(OP_MUL, 32'h0000_0003, 32'h0000_0007, 1'b1, 1'b1);
    run_mul(10);
    check("abort_at_cycle", lat, 11);
    check("abort_busy_done", {30'd0, bus.busy, bus.done}, 32'h0);
    check("abort_result", bus.result, 32'h0);
    check("abort_flags", flags(), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", {30'd0, bus.busy, bus.done}, 32'h0);

    issue(OP_ADD, 32'h2, 32'h3, 1'b0, 1'b0);
    check("post_add_done", {31'd0, bus.done}, 32'h1);
    check("post_add_result", bus.result, 32'h5);
    check("post_add_flags", flags(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
